// File: rtl/bpc_blk_arb.sv
// ---------------------------------------------------------------------------
// bpc_blk_arb
// Block-level arbiter and sequencer that shares one BPC compressor among
// NUM_REQ requesters. Each grant covers exactly one block of BEATS_PER_BLK
// 64-bit beats. The block is framed with sop/eop toward the compressor. The
// requester ID of each granted block is queued in an in-order ID FIFO. When
// the compressor signals the end of a compressed block, the matching ID is
// popped from the FIFO and reported on blk_id_o.
//
// Build option:
//   BPC_ARB_FIXED_PRIO_EN  defined   -> fixed priority, lowest index wins,
//                                       rr_ptr held at 0
//                          undefined -> round-robin starting at rr_ptr
//
// Ports:
//   clk          in   clock
//   rst_n        in   asynchronous active-low reset
//   req_valid_i  in   [NUM_REQ]      per-requester beat valid
//   req_data_i   in   [NUM_REQ*64]   per-requester beat data, r at [64r+:64]
//   req_ready_o  out  [NUM_REQ]      per-requester beat accept
//   cmp_data_o   out  [64]           beat to compressor
//   cmp_valid_o  out                 beat valid to compressor
//   cmp_sop_o    out                 first beat of block
//   cmp_eop_o    out                 last beat of block
//   cmp_valid_i  in                  compressor output valid
//   cmp_eop_i    in                  compressor output end of block
//   blk_done_o   out                 one-cycle pulse, compressed block done
//   blk_id_o     out  [clog2(NUM_REQ)] requester ID of completed block
//   busy_o       out                 in XFER or ID FIFO non-empty
//   err_o        out                 sticky: compressor eop with FIFO empty
// ---------------------------------------------------------------------------
module bpc_blk_arb #(
   parameter int NUM_REQ       = 4,
   parameter int BEATS_PER_BLK = 16,
   parameter int ID_FIFO_DEPTH = 4
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic [NUM_REQ-1:0]           req_valid_i,
   input  logic [NUM_REQ*64-1:0]        req_data_i,
   output logic [NUM_REQ-1:0]           req_ready_o,
   output logic [63:0]                  cmp_data_o,
   output logic                         cmp_valid_o,
   output logic                         cmp_sop_o,
   output logic                         cmp_eop_o,
   input  logic                         cmp_valid_i,
   input  logic                         cmp_eop_i,
   output logic                         blk_done_o,
   output logic [$clog2(NUM_REQ)-1:0]   blk_id_o,
   output logic                         busy_o,
   output logic                         err_o
);

   localparam int IDW = $clog2(NUM_REQ);
   localparam int BCW = $clog2(BEATS_PER_BLK);
   localparam int PW  = $clog2(ID_FIFO_DEPTH);

   localparam logic [BCW-1:0] LAST_BEAT      = BCW'(BEATS_PER_BLK - 1);
   localparam logic [IDW-1:0] LAST_ID        = IDW'(NUM_REQ - 1);
   localparam logic [PW:0]    FIFO_DEPTH_CNT = (PW+1)'(ID_FIFO_DEPTH);
   localparam logic [IDW:0]   NUM_REQ_W      = (IDW+1)'(NUM_REQ);

   typedef enum logic [0:0] {
      ST_IDLE = 1'b0,
      ST_XFER = 1'b1
   } state_t;

   // ------------------------------------------------------------------
   // Registers
   // ------------------------------------------------------------------
   state_t                r_state;
   logic [IDW-1:0]        r_gnt_id;
   logic [BCW-1:0]        r_beat_cnt;
   logic [IDW-1:0]        r_rr_ptr;
   logic [NUM_REQ-1:0]    r_req_ready;
   logic [63:0]           r_cmp_data;
   logic                  r_cmp_valid;
   logic                  r_cmp_sop;
   logic                  r_cmp_eop;
   logic                  r_blk_done;
   logic [IDW-1:0]        r_blk_id;
   logic                  r_err;
   logic [IDW-1:0]        r_fifo_mem [ID_FIFO_DEPTH];
   logic [PW:0]           r_wr_ptr;
   logic [PW:0]           r_rd_ptr;

   // ------------------------------------------------------------------
   // Next-state / combinational wires
   // ------------------------------------------------------------------
   state_t                w_state_nxt;
   logic [IDW-1:0]        w_gnt_id_nxt;
   logic [BCW-1:0]        w_beat_cnt_nxt;
   logic [IDW-1:0]        w_rr_ptr_nxt;
   logic [NUM_REQ-1:0]    w_req_ready_nxt;
   logic [63:0]           w_cmp_data_nxt;
   logic                  w_cmp_valid_nxt;
   logic                  w_cmp_sop_nxt;
   logic                  w_cmp_eop_nxt;
   logic                  w_blk_done_nxt;
   logic [IDW-1:0]        w_blk_id_nxt;
   logic                  w_err_nxt;
   logic                  w_push;
   logic                  w_pop;
   logic                  w_eop_in;

   logic [PW:0]           w_fifo_cnt;
   logic                  w_fifo_empty;
   logic                  w_fifo_full;
   logic [IDW-1:0]        w_fifo_head;

   logic [IDW-1:0]        w_search_base;
   logic [IDW:0]          w_cand;
   logic                  w_win_found;
   logic [IDW-1:0]        w_win_id;

   logic                  w_accept;
   logic [63:0]           w_gnt_data;

   // ------------------------------------------------------------------
   // ID FIFO status. Pointers carry an extra wrap bit so full and empty
   // are distinguishable; full is taken from the pre-pop count, so a push
   // is refused at full even if a pop happens in the same cycle.
   // ------------------------------------------------------------------
   assign w_fifo_cnt   = r_wr_ptr - r_rd_ptr;
   assign w_fifo_empty = (r_wr_ptr == r_rd_ptr);
   assign w_fifo_full  = (w_fifo_cnt == FIFO_DEPTH_CNT);
   assign w_fifo_head  = r_fifo_mem[r_rd_ptr[PW-1:0]];

   // Granted requester's beat and the handshake on it.
   assign w_gnt_data = req_data_i[{r_gnt_id, 6'b000000} +: 64];
   assign w_accept   = (r_state == ST_XFER) & req_valid_i[r_gnt_id]
                     & r_req_ready[r_gnt_id];

`ifdef BPC_ARB_FIXED_PRIO_EN
   assign w_search_base = '0;
`else
   assign w_search_base = r_rr_ptr;
`endif

   // Arbiter: first valid requester at or after the search base, wrapping.
   always_comb begin
      w_win_found = 1'b0;
      w_win_id    = '0;
      w_cand      = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         // base + i never exceeds 2*NUM_REQ-2, so one conditional subtract
         // is enough to wrap it back into range.
         w_cand = {1'b0, w_search_base} + (IDW+1)'(i);
         w_cand = (w_cand >= NUM_REQ_W) ? (w_cand - NUM_REQ_W) : w_cand;
         if (!w_win_found && req_valid_i[w_cand[IDW-1:0]]) begin
            w_win_found = 1'b1;
            w_win_id    = w_cand[IDW-1:0];
         end else begin
            w_win_found = w_win_found;
            w_win_id    = w_win_id;
         end
      end
   end

   // FSM next state, grant bookkeeping and compressor-side beat staging.
   always_comb begin
      w_state_nxt     = r_state;
      w_gnt_id_nxt    = r_gnt_id;
      w_beat_cnt_nxt  = r_beat_cnt;
      w_rr_ptr_nxt    = r_rr_ptr;
      w_req_ready_nxt = r_req_ready;
      w_cmp_data_nxt  = r_cmp_data;
      w_cmp_valid_nxt = 1'b0;
      w_cmp_sop_nxt   = 1'b0;
      w_cmp_eop_nxt   = 1'b0;
      w_push          = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (w_win_found && !w_fifo_full) begin
               w_push          = 1'b1;
               w_gnt_id_nxt    = w_win_id;
               w_beat_cnt_nxt  = '0;
               w_req_ready_nxt = {{(NUM_REQ-1){1'b0}}, 1'b1} << w_win_id;
               w_state_nxt     = ST_XFER;
`ifdef BPC_ARB_FIXED_PRIO_EN
               w_rr_ptr_nxt    = '0;
`else
               w_rr_ptr_nxt    = (w_win_id == LAST_ID) ? '0 : (w_win_id + 1'b1);
`endif
            end else begin
               w_req_ready_nxt = '0;
            end
         end
         ST_XFER: begin
            // A valid gap simply holds the grant; only accepted beats count.
            if (w_accept) begin
               w_cmp_data_nxt  = w_gnt_data;
               w_cmp_valid_nxt = 1'b1;
               w_cmp_sop_nxt   = (r_beat_cnt == '0);
               w_cmp_eop_nxt   = (r_beat_cnt == LAST_BEAT);
               if (r_beat_cnt == LAST_BEAT) begin
                  w_beat_cnt_nxt  = '0;
                  w_req_ready_nxt = '0;
                  w_state_nxt     = ST_IDLE;
               end else begin
                  w_beat_cnt_nxt  = r_beat_cnt + 1'b1;
               end
            end else begin
               w_beat_cnt_nxt = r_beat_cnt;
            end
         end
         default: begin
            w_state_nxt     = ST_IDLE;
            w_req_ready_nxt = '0;
            w_beat_cnt_nxt  = '0;
         end
      endcase
   end

   // Return path: pop on compressor eop, flag an eop with nothing queued.
   always_comb begin
      w_eop_in       = cmp_valid_i & cmp_eop_i;
      w_pop          = w_eop_in & ~w_fifo_empty;
      w_blk_done_nxt = w_pop;
      w_err_nxt      = r_err | (w_eop_in & w_fifo_empty);
      if (w_pop) begin
         w_blk_id_nxt = w_fifo_head;
      end else begin
         w_blk_id_nxt = r_blk_id;
      end
   end

   // FSM state register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Grant, beat counter, round-robin pointer and all registered outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_gnt_id    <= '0;
         r_beat_cnt  <= '0;
         r_rr_ptr    <= '0;
         r_req_ready <= '0;
         r_cmp_data  <= 64'd0;
         r_cmp_valid <= 1'b0;
         r_cmp_sop   <= 1'b0;
         r_cmp_eop   <= 1'b0;
         r_blk_done  <= 1'b0;
         r_blk_id    <= '0;
         r_err       <= 1'b0;
      end else begin
         r_gnt_id    <= w_gnt_id_nxt;
         r_beat_cnt  <= w_beat_cnt_nxt;
         r_rr_ptr    <= w_rr_ptr_nxt;
         r_req_ready <= w_req_ready_nxt;
         r_cmp_data  <= w_cmp_data_nxt;
         r_cmp_valid <= w_cmp_valid_nxt;
         r_cmp_sop   <= w_cmp_sop_nxt;
         r_cmp_eop   <= w_cmp_eop_nxt;
         r_blk_done  <= w_blk_done_nxt;
         r_blk_id    <= w_blk_id_nxt;
         r_err       <= w_err_nxt;
      end
   end

   // ID FIFO storage and pointers; push and pop may happen together.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         for (int i = 0; i < ID_FIFO_DEPTH; i++) begin
            r_fifo_mem[i] <= '0;
         end
      end else begin
         if (w_push) begin
            r_fifo_mem[r_wr_ptr[PW-1:0]] <= w_win_id;
            r_wr_ptr                     <= r_wr_ptr + 1'b1;
         end else begin
            r_wr_ptr <= r_wr_ptr;
         end
         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + 1'b1;
         end else begin
            r_rd_ptr <= r_rd_ptr;
         end
      end
   end

   assign req_ready_o = r_req_ready;
   assign cmp_data_o  = r_cmp_data;
   assign cmp_valid_o = r_cmp_valid;
   assign cmp_sop_o   = r_cmp_sop;
   assign cmp_eop_o   = r_cmp_eop;
   assign blk_done_o  = r_blk_done;
   assign blk_id_o    = r_blk_id;
   assign err_o       = r_err;
   assign busy_o      = (r_state == ST_XFER) | ~w_fifo_empty;

endmodule

// File: tb/tb_bpc_blk_arb.sv
// ---------------------------------------------------------------------------
// Directed self-checking bench for bpc_blk_arb (NUM_REQ=4, 16 beats/block,
// ID FIFO depth 4). Requester streams are driven by a small handshake model
// whose beat data is beat_index + 256*requester.
// ---------------------------------------------------------------------------
module tb_bpc_blk_arb;

   localparam int NR = 4;

   logic              clk;
   logic              rst_n;
   logic [NR-1:0]     req_valid;
   logic [NR*64-1:0]  req_data;
   logic [NR-1:0]     req_ready_o;
   logic [63:0]       cmp_data_o;
   logic              cmp_valid_o;
   logic              cmp_sop_o;
   logic              cmp_eop_o;
   logic              cmp_valid_in;
   logic              cmp_eop_in;
   logic              blk_done_o;
   logic [1:0]        blk_id_o;
   logic              busy_o;
   logic              err_o;

   int n_checks = 0;
   int n_errors = 0;

   int beat        [NR];
   int blocks_left [NR];
   int gap_left    [NR];
   bit gap_en      [NR];
   int gap_beat    = 7;

   int order [4];
   int fifth;

   bpc_blk_arb #(
      .NUM_REQ       (4),
      .BEATS_PER_BLK (16),
      .ID_FIFO_DEPTH (4)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .req_valid_i (req_valid),
      .req_data_i  (req_data),
      .req_ready_o (req_ready_o),
      .cmp_data_o  (cmp_data_o),
      .cmp_valid_o (cmp_valid_o),
      .cmp_sop_o   (cmp_sop_o),
      .cmp_eop_o   (cmp_eop_o),
      .cmp_valid_i (cmp_valid_in),
      .cmp_eop_i   (cmp_eop_in),
      .blk_done_o  (blk_done_o),
      .blk_id_o    (blk_id_o),
      .busy_o      (busy_o),
      .err_o       (err_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic upd_data();
      for (int r = 0; r < NR; r++) begin
         req_data[64*r +: 64] = 64'(beat[r] + 256 * r);
      end
   endtask

   // One clock: note which beats handshake at the coming edge, advance the
   // requester streams after it, leaving time at edge+1 for checks.
   task automatic tick();
      logic [NR-1:0] acc;
      acc = req_valid & req_ready_o;
      @(posedge clk);
      #1;
      for (int r = 0; r < NR; r++) begin
         if (gap_left[r] > 0) begin
            gap_left[r] = gap_left[r] - 1;
            if (gap_left[r] == 0) req_valid[r] = 1'b1;
         end
         if (acc[r]) begin
            beat[r] = beat[r] + 1;
            if (beat[r] == 16) begin
               beat[r] = 0;
               blocks_left[r] = blocks_left[r] - 1;
               if (blocks_left[r] <= 0) req_valid[r] = 1'b0;
            end else if (gap_en[r] && beat[r] == gap_beat) begin
               req_valid[r] = 1'b0;
               gap_left[r]  = 3;
               gap_en[r]    = 1'b0;
            end
         end
      end
      upd_data();
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_ready"}, req_ready_o, 64'd0);
      check({tag, "_cdata"}, cmp_data_o, 64'd0);
      check({tag, "_cvalid"}, cmp_valid_o, 64'd0);
      check({tag, "_sop"}, cmp_sop_o, 64'd0);
      check({tag, "_eop"}, cmp_eop_o, 64'd0);
      check({tag, "_done"}, blk_done_o, 64'd0);
      check({tag, "_id"}, blk_id_o, 64'd0);
      check({tag, "_busy"}, busy_o, 64'd0);
      check({tag, "_err"}, err_o, 64'd0);
   endtask

   initial begin
      logic [NR-1:0] exp_ready;
      logic          exp_valid;

`ifdef BPC_ARB_FIXED_PRIO_EN
      order = '{0, 0, 1, 1};
      fifth = 3;
`else
      order = '{0, 1, 3, 0};
      fifth = 1;
`endif
      rst_n        = 1'b0;
      req_valid    = '0;
      req_data     = '0;
      cmp_valid_in = 1'b0;
      cmp_eop_in   = 1'b0;
      for (int r = 0; r < NR; r++) begin
         beat[r] = 0; blocks_left[r] = 0; gap_left[r] = 0; gap_en[r] = 1'b0;
      end

      // ---------------- reset state
      repeat (2) @(posedge clk);
      #1;
      check_all_zero("rst");
      rst_n = 1'b1;

      // ---------------- single block from requester 2
      blocks_left[2] = 1;
      req_valid[2]   = 1'b1;
      upd_data();
      tick();
      check("t1_grant_ready", req_ready_o, 64'h4);
      check("t1_grant_valid", cmp_valid_o, 64'd0);
      check("t1_grant_busy", busy_o, 64'd1);
      for (int k = 0; k < 16; k++) begin
         tick();
         check("t1_valid", cmp_valid_o, 64'd1);
         check("t1_sop", cmp_sop_o, (k == 0) ? 64'd1 : 64'd0);
         check("t1_eop", cmp_eop_o, (k == 15) ? 64'd1 : 64'd0);
         check("t1_data", cmp_data_o, 64'(512 + k));
         check("t1_ready", req_ready_o, (k == 15) ? 64'd0 : 64'h4);
      end
      check("t1_busy_fifo", busy_o, 64'd1);
      tick();
      check("t1_no_regrant", req_ready_o, 64'd0);
      check("t1_idle_valid", cmp_valid_o, 64'd0);
      cmp_valid_in = 1'b1; cmp_eop_in = 1'b1;
      tick();
      cmp_valid_in = 1'b0; cmp_eop_in = 1'b0;
      check("t1_done", blk_done_o, 64'd1);
      check("t1_id", blk_id_o, 64'd2);
      check("t1_busy_clear", busy_o, 64'd0);
      tick();
      check("t1_done_pulse", blk_done_o, 64'd0);

      // ---------------- round-robin, FIFO fills after 4 blocks
      rst_n = 1'b0;
      #2;
      rst_n = 1'b1;
      blocks_left[0] = 2; blocks_left[1] = 2; blocks_left[3] = 1;
      req_valid = 4'b1011;
      upd_data();
      for (int c = 1; c <= 75; c++) begin
         int n;
         int ph;
         n  = (c - 1) / 17;
         ph = (c - 1) % 17;
         tick();
         if (n < 4) begin
            exp_ready = (ph <= 15) ? (4'b0001 << order[n]) : 4'b0000;
            exp_valid = (ph >= 1);
         end else begin
            exp_ready = 4'b0000;
            exp_valid = 1'b0;
         end
         check("rr_ready", req_ready_o, 64'(exp_ready));
         check("rr_valid", cmp_valid_o, 64'(exp_valid));
         if (exp_valid) begin
            check("rr_sop", cmp_sop_o, (ph == 1) ? 64'd1 : 64'd0);
            check("rr_eop", cmp_eop_o, (ph == 16) ? 64'd1 : 64'd0);
            check("rr_data", cmp_data_o, 64'(order[n] * 256 + ph - 1));
         end
      end
      check("full_busy", busy_o, 64'd1);

      // ---------------- release full FIFO: pop and grant in same cycle
      cmp_valid_in = 1'b1; cmp_eop_in = 1'b1;
      tick();
      check("full_pop0_done", blk_done_o, 64'd1);
      check("full_pop0_id", blk_id_o, 64'(order[0]));
      check("full_denied", req_ready_o, 64'd0);
      tick();
      check("full_pop1_id", blk_id_o, 64'(order[1]));
      check("full_regrant", req_ready_o, 64'(4'b0001 << fifth));
      tick();
      check("full_pop2_id", blk_id_o, 64'(order[2]));
      tick();
      check("full_pop3_id", blk_id_o, 64'(order[3]));
      tick();
      check("full_pop4_done", blk_done_o, 64'd1);
      check("full_pop4_id", blk_id_o, 64'(fifth));
      cmp_valid_in = 1'b0; cmp_eop_in = 1'b0;
      tick();
      check("full_done_low", blk_done_o, 64'd0);
      check("full_busy_xfer", busy_o, 64'd1);
      repeat (12) tick();
      check("full_last_eop", cmp_eop_o, 64'd1);
      check("full_last_data", cmp_data_o, 64'(fifth * 256 + 15));
      check("full_end_ready", req_ready_o, 64'd0);
      check("full_end_busy", busy_o, 64'd0);
      tick();
      for (int r = 0; r < NR; r++) begin
         req_valid[r] = 1'b0; blocks_left[r] = 0; beat[r] = 0;
      end
      upd_data();
      tick();

      // ---------------- valid gap of 3 cycles at beat 7
      blocks_left[2] = 1;
      gap_en[2]      = 1'b1;
      req_valid[2]   = 1'b1;
      upd_data();
      for (int k = 0; k <= 19; k++) begin
         tick();
         check("gap_ready", req_ready_o, (k == 19) ? 64'd0 : 64'h4);
         if (k >= 1) begin
            exp_valid = (k <= 7) || (k >= 11);
            check("gap_valid", cmp_valid_o, 64'(exp_valid));
            if (exp_valid) begin
               check("gap_data", cmp_data_o, 64'(512 + ((k <= 7) ? (k - 1) : (k - 4))));
               check("gap_sop", cmp_sop_o, (k == 1) ? 64'd1 : 64'd0);
               check("gap_eop", cmp_eop_o, (k == 19) ? 64'd1 : 64'd0);
            end
         end
      end
      cmp_valid_in = 1'b1; cmp_eop_in = 1'b1;
      tick();
      cmp_valid_in = 1'b0; cmp_eop_in = 1'b0;
      check("gap_done", blk_done_o, 64'd1);
      check("gap_id", blk_id_o, 64'd2);
      tick();

      // ---------------- compressor eop with empty FIFO
      check("err_pre", err_o, 64'd0);
      cmp_valid_in = 1'b1; cmp_eop_in = 1'b1;
      tick();
      cmp_valid_in = 1'b0; cmp_eop_in = 1'b0;
      check("err_set", err_o, 64'd1);
      check("err_no_done", blk_done_o, 64'd0);
      repeat (3) tick();
      check("err_sticky", err_o, 64'd1);
      check("err_no_done_later", blk_done_o, 64'd0);

      // ---------------- reset in the middle of a block
      blocks_left[1] = 1; blocks_left[3] = 1;
      req_valid = 4'b1010;
      upd_data();
      tick();
      check("mr_grant3", req_ready_o, 64'h8);
      repeat (9) tick();
      check("mr_beat8_valid", cmp_valid_o, 64'd1);
      check("mr_beat8_data", cmp_data_o, 64'(3 * 256 + 8));
      rst_n = 1'b0;
      #1;
      check_all_zero("mr_rst");
      for (int r = 0; r < NR; r++) beat[r] = 0;
      upd_data();
      tick();
      check("mr_in_rst_ready", req_ready_o, 64'd0);
      rst_n = 1'b1;
      tick();
      check("mr_regrant_low", req_ready_o, 64'h2);
      check("mr_regrant_valid", cmp_valid_o, 64'd0);
      tick();
      check("mr_sop_valid", cmp_valid_o, 64'd1);
      check("mr_sop", cmp_sop_o, 64'd1);
      check("mr_sop_data", cmp_data_o, 64'h100);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
